// File: rtl/sbox_share_ctrl_pkg.sv
// Shared types, constants and the S-box lookup used by the time-multiplexed
// S-box controller.
package sbox_share_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ST_RUN = 2'd1,
    KW_RUN = 2'd2
  } ctrl_state_t;

  // Number of bank passes needed to cover a 16-byte state.
  function automatic int chunks(input int nsbox);
    return 16 / nsbox;
  endfunction

  localparam logic [127:0] FIPS_STATE_IN  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_STATE_SUB = 128'h638293c31bfc33f5c4eeacea4bc12816;
  localparam logic [31:0]  FIPS_WORD_IN   = 32'hcf4f3c09;
  localparam logic [31:0]  FIPS_WORD_SUB  = 32'h8a84eb01;

  // Entry for input byte x sits at bits [8*(255-x) +: 8].
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox_lookup(input logic [7:0] x);
    return SBOX_TABLE[8*(255 - int'(x)) +: 8];
  endfunction

endpackage

// File: rtl/sbox_share_ctrl_if.sv
// Request/response bundle between the round datapath / key schedule and the
// shared S-box controller.
interface sbox_share_ctrl_if;

  logic         st_valid;
  logic         st_ready;
  logic [127:0] st_data;
  logic         st_done;
  logic [127:0] st_out;
  logic         kw_valid;
  logic         kw_ready;
  logic [31:0]  kw_word;
  logic         kw_done;
  logic [31:0]  kw_out;
  logic         busy;

  modport master (
    output st_valid, st_data, kw_valid, kw_word,
    input  st_ready, st_done, st_out, kw_ready, kw_done, kw_out, busy
  );

  modport slave (
    input  st_valid, st_data, kw_valid, kw_word,
    output st_ready, st_done, st_out, kw_ready, kw_done, kw_out, busy
  );

endinterface

// File: rtl/sbox_share_ctrl_bank.sv
// Bank of NSBOX independent, purely combinational AES S-box lanes.
// Lane i maps bank_in[8i+7:8i] to bank_out[8i+7:8i].
module aes_sbox
  import sbox_share_ctrl_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  assign out_byte = sbox_lookup(in_byte);

endmodule

module sbox_bank #(
  parameter int NSBOX = 4
) (
  input  logic [8*NSBOX-1:0] bank_in,
  output logic [8*NSBOX-1:0] bank_out
);

  for (genvar i = 0; i < NSBOX; i++) begin : g_lane
    aes_sbox u_sbox (
      .in_byte  (bank_in[8*i +: 8]),
      .out_byte (bank_out[8*i +: 8])
    );
  end

endmodule

// File: rtl/sbox_share_ctrl.sv
// Shares one S-box bank between state SubBytes (CHUNKS passes through a shift
// register) and key-schedule SubWord (single pass on the low four lanes).
module sbox_share_ctrl
  import sbox_share_ctrl_pkg::*;
#(
  parameter int NSBOX    = 4,
  parameter bit KEY_PRIO = 1'b1
) (
  input logic            clk,
  input logic            rst,
  sbox_share_ctrl_if.slave bus
);

  localparam int         CHUNKS     = chunks(NSBOX);
  localparam int         LANE_W     = 8 * NSBOX;
  localparam logic [3:0] LAST_CHUNK = 4'(CHUNKS - 1);

  if (NSBOX != 4 && NSBOX != 8 && NSBOX != 16) begin : g_bad_nsbox
    $error("sbox_share_ctrl: NSBOX must be 4, 8 or 16");
  end

  ctrl_state_t        state_q, state_d;
  logic [3:0]         chunk_q;
  logic [127:0]       shift_q;
  logic [127:0]       shift_next;
  logic [31:0]        word_q;
  logic [LANE_W-1:0]  bank_in;
  logic [LANE_W-1:0]  bank_out;
  logic               st_accept;
  logic               kw_accept;
  logic               last_chunk;

  sbox_bank #(.NSBOX(NSBOX)) u_bank (
    .bank_in  (bank_in),
    .bank_out (bank_out)
  );

  assign bus.busy = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Readies exist only in IDLE; priority decides which one drops on a tie.
  always_comb begin
    state_d      = state_q;
    bus.st_ready = 1'b0;
    bus.kw_ready = 1'b0;
    st_accept    = 1'b0;
    kw_accept    = 1'b0;
    bank_in      = '0;
    last_chunk   = (chunk_q == LAST_CHUNK);
    shift_next   = shift_q << LANE_W;
    shift_next[LANE_W-1:0] = bank_out;

    case (state_q)
      IDLE: begin
        bus.kw_ready = !(bus.st_valid && !KEY_PRIO);
        bus.st_ready = !(bus.kw_valid && KEY_PRIO);
        kw_accept    = bus.kw_valid && bus.kw_ready;
        st_accept    = bus.st_valid && bus.st_ready;
        if (kw_accept) begin
          state_d = KW_RUN;
        end else if (st_accept) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        bank_in = shift_q[127 -: LANE_W];
        if (last_chunk) begin
          state_d = IDLE;
        end
      end
      KW_RUN: begin
        bank_in[31:0] = word_q;
        state_d       = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // After CHUNKS shifts the substituted bytes are back in their original order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chunk_q     <= '0;
      shift_q     <= '0;
      word_q      <= '0;
      bus.st_out  <= '0;
      bus.kw_out  <= '0;
      bus.st_done <= 1'b0;
      bus.kw_done <= 1'b0;
    end else begin
      bus.st_done <= 1'b0;
      bus.kw_done <= 1'b0;
      case (state_q)
        IDLE: begin
          chunk_q <= '0;
          if (st_accept) begin
            shift_q <= bus.st_data;
          end
          if (kw_accept) begin
            word_q <= bus.kw_word;
          end
        end
        ST_RUN: begin
          shift_q <= shift_next;
          chunk_q <= chunk_q + 4'd1;
          if (last_chunk) begin
            chunk_q     <= '0;
            bus.st_out  <= shift_next;
            bus.st_done <= 1'b1;
          end
        end
        KW_RUN: begin
          bus.kw_out  <= bank_out[31:0];
          bus.kw_done <= 1'b1;
        end
        default: begin
          chunk_q <= '0;
        end
      endcase
    end
  end

  a_done_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(bus.st_done && bus.kw_done));

  a_ready_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(bus.st_valid && bus.kw_valid && bus.st_ready && bus.kw_ready));

endmodule
